// File: rtl/mp2_mem_responder_pkg.sv
// Shared types and constants for the mp2 memory responder: FSM states,
// error-cause bit positions and memory word / byte-enable types.
package mp2_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int ERR_WIDTH  = 3;
    localparam int ERR_BOTH   = 0;
    localparam int ERR_CHANGE = 1;
    localparam int ERR_RANGE  = 2;

    localparam int CNT_WIDTH  = 4;

    typedef logic [31:0] mem_word_t;
    typedef logic [3:0]  mem_be_t;

endpackage

// File: rtl/mp2_mem_responder_if.sv
// Unified memory port between the mp2 core (master) and the responder (slave).
interface mp2_mem_responder_if;
    import mp2_mem_pkg::*;

    logic        mem_read;
    logic        mem_write;
    mem_be_t     mem_byte_enable;
    logic [31:0] mem_address;
    mem_word_t   mem_wdata;
    logic        mem_resp;
    mem_word_t   mem_rdata;
    logic        mem_error;
    logic [2:0]  err_cause;

    modport master (
        output mem_read,
        output mem_write,
        output mem_byte_enable,
        output mem_address,
        output mem_wdata,
        input  mem_resp,
        input  mem_rdata,
        input  mem_error,
        input  err_cause
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_byte_enable,
        input  mem_address,
        input  mem_wdata,
        output mem_resp,
        output mem_rdata,
        output mem_error,
        output err_cause
    );

endinterface

// File: rtl/mp2_mem_responder_array.sv
// Single-port word array with per-lane write enables and a registered read
// port; the read register can be loaded with zero for out-of-window reads.
module mp2_mem_array
    import mp2_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  mem_be_t               we_i,
    input  mem_word_t             wdata_i,
    input  logic                  rd_en_i,
    input  logic                  rd_zero_i,
    output mem_word_t             rdata_o
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    mem_word_t words_q [DEPTH];
    mem_word_t rdata_q;

    // Storage is never reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (we_i[lane]) begin
                words_q[idx_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= rd_zero_i ? '0 : words_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mp2_mem_responder.sv
// Single-outstanding memory responder for the mp2 unified memory port:
// fixed-latency FSM, request latch, protocol checker and word array.
module mp2_mem_responder
    import mp2_mem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          LATENCY    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mp2_mem_responder_if.slave bus
);
    localparam logic [63:0]          WINDOW_BYTES = 64'd4 << DEPTH_LOG2;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD     = CNT_WIDTH'(LATENCY - 1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   reqRead_q, reqRead_d;
    logic                   reqWrite_q, reqWrite_d;
    logic [31:0]            addr_q, addr_d;
    logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
    logic                   inWin_q, inWin_d;
    mem_word_t              wdata_q, wdata_d;
    mem_be_t                be_q, be_d;
    logic [ERR_WIDTH-1:0]   errCause_q, errCause_d;
    logic                   memError_q;
    logic                   resp_q;

    logic [31:0]            liveDiff;
    logic                   liveInWin;
    logic [DEPTH_LOG2-1:0]  liveIdx;
    logic                   liveReq;
    logic                   liveBoth;
    logic                   access;
    logic [ERR_WIDTH-1:0]   errSet;

    logic                   srcLive;
    logic [DEPTH_LOG2-1:0]  accIdx;
    logic                   accWrite;
    logic                   accInWin;
    mem_word_t              accWdata;
    mem_be_t                accBe;
    mem_be_t                arrWe;
    logic                   arrRdEn;
    mem_word_t              arrRdata;

    // Modular subtraction: addresses below the base wrap to huge offsets.
    assign liveDiff  = bus.mem_address - BASE_ADDR;
    assign liveInWin = ({32'd0, liveDiff} < WINDOW_BYTES);
    assign liveIdx   = liveDiff[DEPTH_LOG2+1:2];
    assign liveReq   = bus.mem_read ^ bus.mem_write;
    assign liveBoth  = bus.mem_read & bus.mem_write;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reqRead_d  = reqRead_q;
        reqWrite_d = reqWrite_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        inWin_d    = inWin_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        errSet     = '0;
        access     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (liveBoth) begin
                    errSet[ERR_BOTH] = 1'b1;
                end else if (liveReq) begin
                    reqRead_d  = bus.mem_read;
                    reqWrite_d = bus.mem_write;
                    addr_d     = bus.mem_address;
                    idx_d      = liveIdx;
                    inWin_d    = liveInWin;
                    wdata_d    = bus.mem_wdata;
                    be_d       = bus.mem_byte_enable;
                    cnt_d      = CNT_LOAD;
                    errSet[ERR_RANGE] = !liveInWin;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The initiator must hold its request steady until it sees mem_resp.
        if (state_q == WAIT || state_q == RESP) begin
            if (bus.mem_read != reqRead_q || bus.mem_write != reqWrite_q ||
                bus.mem_address != addr_q) begin
                errSet[ERR_CHANGE] = 1'b1;
            end
        end

        errCause_d = errCause_q | errSet;
    end

    // With LATENCY=1 the access happens on the acceptance edge from live inputs.
    assign srcLive  = (state_q == IDLE);
    assign accIdx   = srcLive ? liveIdx             : idx_q;
    assign accWrite = srcLive ? bus.mem_write       : reqWrite_q;
    assign accInWin = srcLive ? liveInWin           : inWin_q;
    assign accWdata = srcLive ? bus.mem_wdata       : wdata_q;
    assign accBe    = srcLive ? bus.mem_byte_enable : be_q;
    assign arrWe    = (access && accWrite && accInWin) ? accBe : '0;
    assign arrRdEn  = access && !accWrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            reqRead_q  <= 1'b0;
            reqWrite_q <= 1'b0;
            addr_q     <= '0;
            idx_q      <= '0;
            inWin_q    <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            errCause_q <= '0;
            memError_q <= 1'b0;
            resp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reqRead_q  <= reqRead_d;
            reqWrite_q <= reqWrite_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            inWin_q    <= inWin_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            errCause_q <= errCause_d;
            memError_q <= |errCause_d;
            resp_q     <= (state_d == RESP);
        end
    end

    mp2_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx_i     (accIdx),
        .we_i      (arrWe),
        .wdata_i   (accWdata),
        .rd_en_i   (arrRdEn),
        .rd_zero_i (!accInWin),
        .rdata_o   (arrRdata)
    );

    assign bus.mem_resp  = resp_q;
    assign bus.mem_rdata = arrRdata;
    assign bus.mem_error = memError_q;
    assign bus.err_cause = errCause_q;

endmodule

// File: tb/tb_mp2_mem_responder.sv
// Bench for mp2_mem_responder: a LATENCY=3 and a LATENCY=1 instance checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_mp2_mem_responder;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] WIN  = 32'h0001_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    logic        rdReq   [2];
    logic        wrReq   [2];
    logic [3:0]  beReq   [2];
    logic [31:0] addrReq [2];
    logic [31:0] wdReq   [2];

    logic        outResp  [2];
    logic [31:0] outRdata [2];
    logic        outError [2];
    logic [2:0]  outCause [2];

    mp2_mem_responder_if bus3();
    mp2_mem_responder_if bus1();

    assign bus3.mem_read        = rdReq[0];
    assign bus3.mem_write       = wrReq[0];
    assign bus3.mem_byte_enable = beReq[0];
    assign bus3.mem_address     = addrReq[0];
    assign bus3.mem_wdata       = wdReq[0];
    assign outResp[0]  = bus3.mem_resp;
    assign outRdata[0] = bus3.mem_rdata;
    assign outError[0] = bus3.mem_error;
    assign outCause[0] = bus3.err_cause;

    assign bus1.mem_read        = rdReq[1];
    assign bus1.mem_write       = wrReq[1];
    assign bus1.mem_byte_enable = beReq[1];
    assign bus1.mem_address     = addrReq[1];
    assign bus1.mem_wdata       = wdReq[1];
    assign outResp[1]  = bus1.mem_resp;
    assign outRdata[1] = bus1.mem_rdata;
    assign outError[1] = bus1.mem_error;
    assign outCause[1] = bus1.err_cause;

    mp2_mem_responder #(.DEPTH_LOG2(14), .BASE_ADDR(BASE), .LATENCY(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    mp2_mem_responder #(.DEPTH_LOG2(14), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int k, input logic r, input logic w, input logic [3:0] b,
                                 input logic [31:0] a, input logic [31:0] d);
        rdReq[k]   = r;
        wrReq[k]   = w;
        beReq[k]   = b;
        addrReq[k] = a;
        wdReq[k]   = d;
    endtask

    // Transaction-level model: each accepted request answers LATENCY cycles
    // later; the request must stay unchanged from acceptance to the answer.
    bit          mActive   [2];
    int          mAcc      [2];
    int          mRespCyc  [2];
    logic        mWr       [2];
    logic        mRd       [2];
    logic [31:0] mAddr     [2];
    logic [31:0] mWd       [2];
    logic [3:0]  mBe       [2];
    logic [31:0] mExpRdata [2];
    logic [2:0]  mExpErr   [2];
    logic [31:0] mMem      [int];

    function automatic int latOf(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    task automatic modelStep(input int k);
        logic        expResp;
        logic [31:0] diff;
        logic [31:0] word;
        int          key;
        if (!rst_n) begin
            mActive[k]   = 1'b0;
            mExpRdata[k] = '0;
            mExpErr[k]   = '0;
        end
        expResp = mActive[k] && (cyc == mRespCyc[k]);
        if (expResp) begin
            diff = mAddr[k] - BASE;
            key  = k * (1 << 20) + int'(diff >> 2);
            if (diff < WIN) begin
                word = mMem.exists(key) ? mMem[key] : 32'h0;
                if (mWr[k]) begin
                    for (int i = 0; i < 4; i++)
                        if (mBe[k][i]) word[8*i +: 8] = mWd[k][8*i +: 8];
                    mMem[key] = word;
                end else begin
                    mExpRdata[k] = word;
                end
            end else if (!mWr[k]) begin
                mExpRdata[k] = 32'h0;
            end
        end
        checkOutput($sformatf("resp[%0d]", k), 32'(outResp[k]), 32'(expResp));
        checkOutput($sformatf("rdata[%0d]", k), outRdata[k], mExpRdata[k]);
        checkOutput($sformatf("errCause[%0d]", k), 32'(outCause[k]), 32'(mExpErr[k]));
        checkOutput($sformatf("memError[%0d]", k), 32'(outError[k]), 32'(|mExpErr[k]));
        if (!rst_n) return;
        if (mActive[k] && cyc > mAcc[k] && cyc <= mRespCyc[k]) begin
            if (rdReq[k] != mRd[k] || wrReq[k] != mWr[k] || addrReq[k] != mAddr[k])
                mExpErr[k][1] = 1'b1;
        end else if (rdReq[k] && wrReq[k]) begin
            mExpErr[k][0] = 1'b1;
        end else if (rdReq[k] || wrReq[k]) begin
            mActive[k]  = 1'b1;
            mAcc[k]     = cyc;
            mRespCyc[k] = cyc + latOf(k);
            mRd[k]      = rdReq[k];
            mWr[k]      = wrReq[k];
            mAddr[k]    = addrReq[k];
            mWd[k]      = wdReq[k];
            mBe[k]      = beReq[k];
            if ((addrReq[k] - BASE) >= WIN) mExpErr[k][2] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            modelStep(0);
            modelStep(1);
        end
    end

    // Drives one request, waits for mem_resp and releases it in the next cycle.
    task automatic doTxn(input int k, input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d,
                         output int rc, output logic [31:0] rdat);
        applyStimulus(k, r, w, b, a, d);
        rc   = -1;
        rdat = '0;
        for (int i = 0; i < 20 && rc < 0; i++) begin
            @(negedge clk);
            if (outResp[k]) begin
                rc   = cyc;
                rdat = outRdata[k];
            end
        end
        @(posedge clk);
        #2;
        applyStimulus(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        int          rc;
        int          stc;
        logic [31:0] rdat;
        logic [3:0]  pat;
        logic        seen;

        for (int k = 0; k < 2; k++) begin
            applyStimulus(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            mActive[k]   = 1'b0;
            mAcc[k]      = 0;
            mRespCyc[k]  = 0;
            mExpRdata[k] = '0;
            mExpErr[k]   = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rstResp", 32'(outResp[0]), 32'h0);
        checkOutput("rstRdata", outRdata[0], 32'h0);
        checkOutput("rstCause", 32'(outCause[0]), 32'h0);
        checkOutput("rstError", 32'(outError[0]), 32'h0);
        rst_n = 1'b1;

        while (cyc < 10) begin
            @(posedge clk);
            #2;
        end
        doTxn(0, 1'b0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, rc, rdat);
        checkOutput("wrRespCycle", rc, 32'd13);
        doTxn(0, 1'b1, 1'b0, 4'h0, BASE + 32'h10, 32'h0, rc, rdat);
        checkOutput("rdRespCycle", rc, 32'd17);
        checkOutput("rdData", rdat, 32'hDEAD_BEEF);

        doTxn(0, 1'b0, 1'b1, 4'b0010, BASE + 32'h10, 32'h0000_AB00, rc, rdat);
        doTxn(0, 1'b1, 1'b0, 4'h0, BASE + 32'h10, 32'h0, rc, rdat);
        checkOutput("laneData", rdat, 32'hDEAD_ABEF);
        stc = cyc;
        doTxn(0, 1'b0, 1'b1, 4'b0000, BASE + 32'h10, 32'hFFFF_FFFF, rc, rdat);
        checkOutput("be0Latency", rc - stc, 32'd3);
        doTxn(0, 1'b1, 1'b0, 4'h0, BASE + 32'h10, 32'h0, rc, rdat);
        checkOutput("be0Data", rdat, 32'hDEAD_ABEF);

        stc = cyc;
        doTxn(1, 1'b0, 1'b1, 4'hF, BASE, 32'hCAFE_F00D, rc, rdat);
        checkOutput("lat1Latency", rc - stc, 32'd1);
        applyStimulus(1, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = outResp[1];
        end
        @(posedge clk);
        #2;
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("b2bPattern", 32'(pat), 32'b1010);
        checkOutput("b2bError", 32'(outError[1]), 32'h0);
        checkOutput("b2bData", outRdata[1], 32'hCAFE_F00D);

        doTxn(0, 1'b0, 1'b1, 4'hF, BASE, 32'hA5A5_A5A5, rc, rdat);
        doTxn(0, 1'b0, 1'b1, 4'hF, BASE + 32'h4, 32'h0BAD_F00D, rc, rdat);
        stc = cyc;
        doTxn(0, 1'b1, 1'b0, 4'h0, 32'h3FFF_FFFC, 32'h0, rc, rdat);
        checkOutput("oowRdLatency", rc - stc, 32'd3);
        checkOutput("oowRdData", rdat, 32'h0);
        checkOutput("oowCause", 32'(outCause[0]), 32'b100);
        stc = cyc;
        doTxn(0, 1'b0, 1'b1, 4'hF, 32'h4001_0000, 32'h1234_5678, rc, rdat);
        checkOutput("oowWrLatency", rc - stc, 32'd3);
        doTxn(0, 1'b1, 1'b0, 4'h0, BASE, 32'h0, rc, rdat);
        checkOutput("oowWrDropped", rdat, 32'hA5A5_A5A5);

        applyStimulus(0, 1'b1, 1'b1, 4'hF, BASE, 32'h0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (outResp[0]) seen = 1'b1;
        end
        @(posedge clk);
        #2;
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("bothNoResp", 32'(seen), 32'h0);
        checkOutput("bothCause", 32'(outCause[0]), 32'b101);

        stc = cyc;
        applyStimulus(0, 1'b1, 1'b0, 4'h0, BASE, 32'h0);
        @(posedge clk);
        #2;
        addrReq[0] = BASE + 32'h4;
        rc = -1;
        rdat = '0;
        for (int i = 0; i < 20 && rc < 0; i++) begin
            @(negedge clk);
            if (outResp[0]) begin
                rc   = cyc;
                rdat = outRdata[0];
            end
        end
        @(posedge clk);
        #2;
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("chgLatency", rc - stc, 32'd3);
        checkOutput("chgData", rdat, 32'hA5A5_A5A5);
        checkOutput("chgCause", 32'(outCause[0]), 32'b111);

        doTxn(0, 1'b0, 1'b1, 4'hF, BASE + 32'h20, 32'h1111_2222, rc, rdat);
        applyStimulus(0, 1'b0, 1'b1, 4'hF, BASE + 32'h20, 32'h3333_4444);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abortResp", 32'(outResp[0]), 32'h0);
        checkOutput("abortRdata", outRdata[0], 32'h0);
        checkOutput("abortCause", 32'(outCause[0]), 32'h0);
        checkOutput("abortError", 32'(outError[0]), 32'h0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (outResp[0]) seen = 1'b1;
        end
        checkOutput("abortNoResp", 32'(seen), 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        doTxn(0, 1'b1, 1'b0, 4'h0, BASE + 32'h20, 32'h0, rc, rdat);
        checkOutput("abortOldData", rdat, 32'h1111_2222);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
